// File: rtl/bits_eq_lock_monitor.sv
// Registered equality monitor: tracks runs of I0==I1 samples, drives a
// SEARCH/LOCKED state machine and saturating match/mismatch statistics.
module bits_eq_lock_monitor #(
   parameter int WIDTH        = 3,
   parameter int LOCK_COUNT   = 4,
   parameter int UNLOCK_COUNT = 2,
   parameter int CNT_WIDTH    = 8
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic [WIDTH-1:0]     I0,
   input  logic [WIDTH-1:0]     I1,
   input  logic                 valid,
   input  logic                 clear,
   output logic                 O,
   output logic                 O_valid,
   output logic                 locked,
   output logic                 lock_event,
   output logic                 unlock_event,
   output logic [CNT_WIDTH-1:0] match_count,
   output logic [CNT_WIDTH-1:0] mismatch_count
);

   localparam int RUN_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
   localparam int RUN_W   = $clog2(RUN_MAX + 1);

   localparam logic [RUN_W-1:0]     LOCK_TGT   = RUN_W'(LOCK_COUNT);
   localparam logic [RUN_W-1:0]     UNLOCK_TGT = RUN_W'(UNLOCK_COUNT);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t           state;
   logic [RUN_W-1:0] run;
   logic [RUN_W-1:0] run_inc;
   logic             eq;

   assign eq      = (I0 == I1);
   assign run_inc = run + 1'b1;
   // state is a flop, so locked carries no combinational path from the inputs
   assign locked  = (state == LOCKED);

   // NOTE: all state here is sequential, so every assignment below is
   // non-blocking; blocking writes would make the update order observable.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state          <= SEARCH;
         run            <= '0;
         O              <= 1'b0;
         O_valid        <= 1'b0;
         lock_event     <= 1'b0;
         unlock_event   <= 1'b0;
         match_count    <= '0;
         mismatch_count <= '0;
      end else begin
         O_valid      <= 1'b0;
         lock_event   <= 1'b0;
         unlock_event <= 1'b0;
         if (clear) begin
            // O deliberately keeps the last accepted result across a clear
            state          <= SEARCH;
            run            <= '0;
            match_count    <= '0;
            mismatch_count <= '0;
         end else if (valid) begin
            O       <= eq;
            O_valid <= 1'b1;
            if (eq) begin
               if (match_count != CNT_MAX) match_count <= match_count + 1'b1;
            end else begin
               if (mismatch_count != CNT_MAX) mismatch_count <= mismatch_count + 1'b1;
            end
            // run counts matches while searching and mismatches while locked
            case (state)
               SEARCH: begin
                  if (!eq) begin
                     run <= '0;
                  end else if (run_inc == LOCK_TGT) begin
                     state      <= LOCKED;
                     run        <= '0;
                     lock_event <= 1'b1;
                  end else begin
                     run <= run_inc;
                  end
               end
               LOCKED: begin
                  if (eq) begin
                     run <= '0;
                  end else if (run_inc == UNLOCK_TGT) begin
                     state        <= SEARCH;
                     run          <= '0;
                     unlock_event <= 1'b1;
                  end else begin
                     run <= run_inc;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bits_eq_lock_monitor.sv
// Directed bench for bits_eq_lock_monitor: a reference model pushes expected
// outputs to a scoreboard queue as stimulus is driven; they are popped after the edge.
module tb_bits_eq_lock_monitor;

   localparam int WIDTH = 3;

   logic             CLK = 1'b0;
   logic             RESET;
   logic [WIDTH-1:0] I0, I1;
   logic             valid, clear;

   logic       o_m, ov_m, lk_m, le_m, ue_m;
   logic [7:0] mc_m, mmc_m;
   logic       o_s, ov_s, lk_s, le_s, ue_s;
   logic [1:0] mc_s, mmc_s;
   logic       o_1, ov_1, lk_1, le_1, ue_1;
   logic [7:0] mc_1, mmc_1;

   always #5 CLK = ~CLK;

   bits_eq_lock_monitor #(.WIDTH(WIDTH), .LOCK_COUNT(4), .UNLOCK_COUNT(2), .CNT_WIDTH(8)) dut_main (
      .CLK(CLK), .RESET(RESET), .I0(I0), .I1(I1), .valid(valid), .clear(clear),
      .O(o_m), .O_valid(ov_m), .locked(lk_m), .lock_event(le_m), .unlock_event(ue_m),
      .match_count(mc_m), .mismatch_count(mmc_m));

   bits_eq_lock_monitor #(.WIDTH(WIDTH), .LOCK_COUNT(4), .UNLOCK_COUNT(2), .CNT_WIDTH(2)) dut_sat (
      .CLK(CLK), .RESET(RESET), .I0(I0), .I1(I1), .valid(valid), .clear(clear),
      .O(o_s), .O_valid(ov_s), .locked(lk_s), .lock_event(le_s), .unlock_event(ue_s),
      .match_count(mc_s), .mismatch_count(mmc_s));

   bits_eq_lock_monitor #(.WIDTH(WIDTH), .LOCK_COUNT(1), .UNLOCK_COUNT(1), .CNT_WIDTH(8)) dut_one (
      .CLK(CLK), .RESET(RESET), .I0(I0), .I1(I1), .valid(valid), .clear(clear),
      .O(o_1), .O_valid(ov_1), .locked(lk_1), .lock_event(le_1), .unlock_event(ue_1),
      .match_count(mc_1), .mismatch_count(mmc_1));

   typedef struct {
      bit st;
      int run;
      bit le;
      bit ue;
      int mc;
      int mmc;
   } model_t;

   typedef struct {
      bit     o;
      bit     ov;
      model_t m;
      model_t s;
      model_t one;
   } exp_t;

   model_t mod_main, mod_sat, mod_one;
   bit     mod_o, mod_ov;
   exp_t   sb_q[$];
   int     checks   = 0;
   int     failures = 0;

   function automatic model_t model_step(model_t cur, int lock_n, int unlock_n, int cmax,
                                         bit rst, bit clr, bit vld, bit eq);
      model_t nxt;
      nxt    = cur;
      nxt.le = 1'b0;
      nxt.ue = 1'b0;
      if (rst || clr) begin
         nxt.st  = 1'b0;
         nxt.run = 0;
         nxt.mc  = 0;
         nxt.mmc = 0;
      end else if (vld) begin
         if (eq) nxt.mc = (cur.mc < cmax) ? cur.mc + 1 : cmax;
         else    nxt.mmc = (cur.mmc < cmax) ? cur.mmc + 1 : cmax;
         if (!cur.st) begin
            if (!eq) nxt.run = 0;
            else if (cur.run + 1 == lock_n) begin nxt.st = 1'b1; nxt.run = 0; nxt.le = 1'b1; end
            else nxt.run = cur.run + 1;
         end else begin
            if (eq) nxt.run = 0;
            else if (cur.run + 1 == unlock_n) begin nxt.st = 1'b0; nxt.run = 0; nxt.ue = 1'b1; end
            else nxt.run = cur.run + 1;
         end
      end
      return nxt;
   endfunction

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Drive one cycle of stimulus, push the expected result, then pop and compare after the edge.
   task automatic step(input bit rst, input bit clr, input bit vld, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b);
      exp_t e;
      bit   eq;
      @(negedge CLK);
      RESET = rst; clear = clr; valid = vld; I0 = a; I1 = b;
      eq = (a == b);
      mod_main = model_step(mod_main, 4, 2, 255, rst, clr, vld, eq);
      mod_sat  = model_step(mod_sat,  4, 2, 3,   rst, clr, vld, eq);
      mod_one  = model_step(mod_one,  1, 1, 255, rst, clr, vld, eq);
      if (rst)      begin mod_o = 1'b0; mod_ov = 1'b0; end
      else if (clr) mod_ov = 1'b0;
      else if (vld) begin mod_o = eq; mod_ov = 1'b1; end
      else          mod_ov = 1'b0;
      e.o = mod_o; e.ov = mod_ov; e.m = mod_main; e.s = mod_sat; e.one = mod_one;
      sb_q.push_back(e);
      @(posedge CLK);
      #1;
      e = sb_q.pop_front();
      check("O",              {31'b0, o_m},  {31'b0, e.o});
      check("O_valid",        {31'b0, ov_m}, {31'b0, e.ov});
      check("locked",         {31'b0, lk_m}, {31'b0, e.m.st});
      check("lock_event",     {31'b0, le_m}, {31'b0, e.m.le});
      check("unlock_event",   {31'b0, ue_m}, {31'b0, e.m.ue});
      check("match_count",    {24'b0, mc_m}, e.m.mc);
      check("mismatch_count", {24'b0, mmc_m}, e.m.mmc);
      check("sat_match",      {30'b0, mc_s}, e.s.mc);
      check("sat_mismatch",   {30'b0, mmc_s}, e.s.mmc);
      check("one_locked",     {31'b0, lk_1}, {31'b0, e.one.st});
      check("one_lock_ev",    {31'b0, le_1}, {31'b0, e.one.le});
      check("one_unlock_ev",  {31'b0, ue_1}, {31'b0, e.one.ue});
   endtask

   initial begin
      RESET = 1'b1; clear = 1'b0; valid = 1'b0; I0 = '0; I1 = '0;
      mod_main = '{default: 0}; mod_sat = '{default: 0}; mod_one = '{default: 0};
      mod_o = 1'b0; mod_ov = 1'b0;

      // reset held with a valid matching sample present
      step(1, 0, 1, 3'd5, 3'd5);
      step(1, 0, 1, 3'd5, 3'd5);
      check("rst_O", {31'b0, o_m}, 0);
      step(0, 0, 0, 3'd5, 3'd5);
      check("post_rst_locked", {31'b0, lk_m}, 0);
      check("post_rst_match", {24'b0, mc_m}, 0);

      // lock entry after four matches
      repeat (3) step(0, 0, 1, 3'd3, 3'd3);
      check("lock_pre", {31'b0, lk_m}, 0);
      step(0, 0, 1, 3'd3, 3'd3);
      check("lock_locked", {31'b0, lk_m}, 1);
      check("lock_event_pulse", {31'b0, le_m}, 1);
      check("lock_match4", {24'b0, mc_m}, 4);
      step(0, 0, 0, 3'd0, 3'd0);
      check("lock_event_drop", {31'b0, le_m}, 0);

      // run break: gaps hold the run, a mismatch restarts it
      step(0, 1, 0, 3'd0, 3'd0);
      step(0, 0, 1, 3'd3, 3'd3);
      step(0, 0, 1, 3'd3, 3'd3);
      repeat (3) step(0, 0, 0, 3'd3, 3'd3);
      step(0, 0, 1, 3'd3, 3'd2);
      repeat (3) step(0, 0, 1, 3'd3, 3'd3);
      check("brk_not_locked", {31'b0, lk_m}, 0);
      step(0, 0, 1, 3'd3, 3'd3);
      check("brk_locked", {31'b0, lk_m}, 1);
      check("brk_match6", {24'b0, mc_m}, 6);
      check("brk_mismatch1", {24'b0, mmc_m}, 1);

      // unlock: a match between mismatches restarts the mismatch run
      step(0, 0, 1, 3'd1, 3'd6);
      step(0, 0, 1, 3'd6, 3'd6);
      step(0, 0, 1, 3'd7, 3'd6);
      check("unl_hold", {31'b0, lk_m}, 1);
      step(0, 0, 1, 3'd0, 3'd4);
      check("unl_event", {31'b0, ue_m}, 1);
      check("unl_locked", {31'b0, lk_m}, 0);
      step(0, 0, 0, 3'd0, 3'd0);
      check("unl_event_drop", {31'b0, ue_m}, 0);

      // saturation of the 2-bit counters, then lock again
      step(0, 1, 0, 3'd0, 3'd0);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 3'd2, 3'd1);
      check("sat_mismatch3", {30'b0, mmc_s}, 3);
      step(0, 1, 0, 3'd0, 3'd0);
      for (int i = 0; i < 6; i++) step(0, 0, 1, 3'(i), 3'(i));
      check("sat_match3", {30'b0, mc_s}, 3);
      check("sat_wide6", {24'b0, mc_m}, 6);

      // clear beats a valid sample while locked
      step(0, 1, 1, 3'd4, 3'd4);
      check("clr_locked", {31'b0, lk_m}, 0);
      check("clr_O_hold", {31'b0, o_m}, 1);
      check("clr_O_valid", {31'b0, ov_m}, 0);
      check("clr_no_event", {30'b0, le_m, ue_m}, 0);
      check("clr_counts", {16'b0, mc_m, mmc_m}, 0);

      // reset beats clear
      step(0, 0, 1, 3'd4, 3'd4);
      step(1, 1, 1, 3'd4, 3'd4);
      check("rstclr_O", {31'b0, o_m}, 0);
      check("rstclr_match", {24'b0, mc_m}, 0);
      step(0, 0, 0, 3'd0, 3'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bits_eq_lock_monitor.md
Name: bits_eq_lock_monitor

Overview:
- Sequential consumer of a WIDTH-bit equality compare (I0 == I1, as produced by the Bits eq stage).
- Registers the per-sample equality result.
- Tracks runs of consecutive matches and mismatches.
- Drives a lock/unlock state machine and saturating match/mismatch statistics counters, used by downstream pattern-alignment logic.

Parameters:
WIDTH, 3, operand width of I0/I1
LOCK_COUNT, 4, consecutive matching valid samples required to enter LOCKED (>=1)
UNLOCK_COUNT, 2, consecutive mismatching valid samples required to leave LOCKED (>=1)
CNT_WIDTH, 8, width of statistics counters

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  synchronous active-high reset
I0  input  WIDTH  operand A
I1  input  WIDTH  operand B
valid  input  1  I0/I1 hold a sample this cycle
clear  input  1  synchronous clear of FSM and counters
O  output  1  registered I0==I1 of last accepted sample
O_valid  output  1  O updated this cycle (registered valid)
locked  output  1  FSM in LOCKED
lock_event  output  1  one-cycle pulse on SEARCH->LOCKED
unlock_event  output  1  one-cycle pulse on LOCKED->SEARCH
match_count  output  CNT_WIDTH  saturating count of matching valid samples
mismatch_count  output  CNT_WIDTH  saturating count of mismatching valid samples

Behaviour:
- Interface: one clock CLK; RESET is synchronous and active-high.
- Reset: RESET=1 at a rising edge forces:
  - O=0, O_valid=0, locked=0, lock_event=0, unlock_event=0
  - match_count=0, mismatch_count=0
  - run counter=0, FSM=SEARCH
- Reset mid-run discards all history. No sample is accepted on a reset cycle.
- Priority: RESET > clear > valid.
- clear=1 (RESET=0) has the same effect as reset on FSM, run counter and statistics, with these differences:
  - O holds its value.
  - O_valid=0.
  - Any simultaneous valid sample is dropped: not counted, O not updated.
- Equality: eq = (I0 == I1) across all WIDTH bits, unsigned, combinational inside the block.
- Latency: for an accepted sample (valid=1, no reset/clear) at edge k:
  - O=eq and O_valid=1 after edge k.
  - Counters and FSM update at the same edge.
  - With valid=0: O holds, O_valid=0, no other state changes, run counter holds (gaps do not break runs).
- Statistics: on an accepted sample, eq=1 increments match_count and eq=0 increments mismatch_count. Each saturates at 2^CNT_WIDTH-1 with no wrap.
- Run counter (internal, width enough for max(LOCK_COUNT,UNLOCK_COUNT)):
  - SEARCH: counts consecutive matches; mismatch resets it to 0.
  - LOCKED: counts consecutive mismatches; match resets it to 0.
- FSM:
  - SEARCH: accepted eq=1 with run+1 == LOCK_COUNT -> LOCKED, run=0, lock_event=1 next cycle. Otherwise stay.
  - LOCKED: accepted eq=0 with run+1 == UNLOCK_COUNT -> SEARCH, run=0, unlock_event=1 next cycle. Otherwise stay.
- locked, lock_event and unlock_event are registered and change at the same edge as O for the triggering sample.
- Event pulses last exactly one cycle.
- LOCK_COUNT=1 locks on the first match; UNLOCK_COUNT=1 unlocks on the first mismatch.
- No combinational path from inputs to outputs.

Test Plan:
- Reset check: RESET=1 for 2 cycles with valid=1, I0=I1=5 -> all outputs 0 and counts 0 during reset and the first cycle after release.
- Lock entry: I0=I1=3 valid for 4 cycles -> O=1 each cycle; locked=1 and lock_event=1 after 4th edge; lock_event=0 next cycle; match_count=4.
- Run break: sequence match, match, valid=0 gap of 3 cycles, mismatch (I0=3, I1=2), match x4 -> gap keeps run at 2; mismatch resets run; locks only after the final 4th match; mismatch_count=1, match_count=6.
- Unlock: while locked, send mismatch, match, mismatch, mismatch -> stays locked through the first three samples; unlock_event pulse and locked=0 after the 4th.
- Saturation with CNT_WIDTH=2: 6 matches -> match_count stops at 3, no wrap.
- Clear vs valid: clear=1 with valid=1, I0=I1 while locked -> locked=0, counts 0, O unchanged, O_valid=0, no event pulse. Repeat with RESET and clear both high -> reset values.
